// File: rtl/pll_lock_ce_gen.sv
// PLL lock debouncer: core reset release and 32.768 kHz clock-enable generation.
// Optional loss counter output enabled by defining PLL_LOCK_CE_GEN_LOSS_COUNT_EN.
module pll_lock_ce_gen #(
  parameter int unsigned CLK_DIV     = 400,
  parameter int unsigned TURBO_DIV   = 25,
  parameter int unsigned LOCK_STABLE = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       turbo,
  input  logic       pause,
  output logic       core_reset_n,
  output logic       ce_32k,
  output logic       running,
  output logic       lock_lost
`ifdef PLL_LOCK_CE_GEN_LOSS_COUNT_EN
  ,
  output logic [7:0] loss_count
`endif
);

  localparam logic [11:0] NORM_DIV    = 12'(CLK_DIV);
  localparam logic [11:0] FAST_DIV    = 12'(TURBO_DIV);
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Out-of-range parameters stop elaboration.
  if (CLK_DIV < 2 || CLK_DIV > 4095) begin : g_chk_clk_div
    $error("pll_lock_ce_gen: CLK_DIV=%0d outside 2..4095", CLK_DIV);
  end
  if (TURBO_DIV < 2 || TURBO_DIV > CLK_DIV) begin : g_chk_turbo_div
    $error("pll_lock_ce_gen: TURBO_DIV=%0d outside 2..CLK_DIV", TURBO_DIV);
  end
  if (LOCK_STABLE < 1 || LOCK_STABLE > 65535) begin : g_chk_lock_stable
    $error("pll_lock_ce_gen: LOCK_STABLE=%0d outside 1..65535", LOCK_STABLE);
  end

  logic        lk_meta;
  logic        lk_s;
  state_t      state;
  state_t      state_next;
  logic [15:0] stable_cnt;
  logic [15:0] stable_next;
  logic [11:0] div_cnt;
  logic [11:0] div_next;
  logic [11:0] div_latched;
  logic [11:0] div_latched_next;
  logic [11:0] div_last;
  logic        wrap;
  logic        run_ok;
  logic        enter_run;
  logic        run_exit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage samples its pre-edge value; blocking would merge both stages.
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_next  = state;
    stable_next = stable_cnt;
    unique case (state)
      WAIT_LOCK: begin
        stable_next = '0;
        if (lk_s) begin
          // This cycle is already the first stable one.
          if (LOCK_STABLE == 1) begin
            state_next = RUN;
          end else begin
            state_next  = STABILIZE;
            stable_next = 16'd1;
          end
        end
      end
      STABILIZE: begin
        if (!lk_s) begin
          state_next  = WAIT_LOCK;
          stable_next = '0;
        end else if (stable_cnt == STABLE_LAST) begin
          state_next  = RUN;
          stable_next = '0;
        end else begin
          stable_next = stable_cnt + 16'd1;
        end
      end
      RUN: begin
        stable_next = '0;
        if (!lk_s) state_next = WAIT_LOCK;
      end
      default: begin
        state_next  = WAIT_LOCK;
        stable_next = '0;
      end
    endcase
  end

  assign enter_run = (state != RUN) && (state_next == RUN);
  assign run_exit  = (state == RUN) && !lk_s;

  // Lock loss overrides everything: the pulse is masked and the divider clears.
  always_comb begin
    div_last         = div_latched - 12'd1;
    wrap             = (div_cnt == div_last);
    run_ok           = (state == RUN) && lk_s;
    ce_32k           = run_ok && !pause && wrap;
    div_next         = div_cnt;
    div_latched_next = div_latched;
    if (!run_ok) begin
      div_next = '0;
    end else if (!pause) begin
      div_next = wrap ? 12'd0 : div_cnt + 12'd1;
    end
    // turbo only lands on a period boundary, so no period is ever cut or stretched.
    if (enter_run || ce_32k) begin
      div_latched_next = turbo ? FAST_DIV : NORM_DIV;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_LOCK;
      stable_cnt   <= '0;
      div_cnt      <= '0;
      div_latched  <= NORM_DIV;
      core_reset_n <= 1'b0;
      running      <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      state        <= state_next;
      stable_cnt   <= stable_next;
      div_cnt      <= div_next;
      div_latched  <= div_latched_next;
      core_reset_n <= (state_next == RUN);
      running      <= (state_next == RUN);
      lock_lost    <= lock_lost | run_exit;
    end
  end

`ifdef PLL_LOCK_CE_GEN_LOSS_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_count <= '0;
    end else if (run_exit && (loss_count != 8'hFF)) begin
      loss_count <= loss_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_ce_gen.sv
// Self-checking bench for pll_lock_ce_gen: vector table plus hand-written timing sequences.
module tb_pll_lock_ce_gen;

  localparam int CLK_DIV     = 400;
  localparam int TURBO_DIV   = 25;
  localparam int LOCK_STABLE = 1024;
  localparam int REL         = LOCK_STABLE + 2;

  logic clk        = 1'b0;
  logic reset_n    = 1'b1;
  logic pll_locked = 1'b0;
  logic turbo      = 1'b0;
  logic pause      = 1'b0;
  logic core_reset_n;
  logic ce_32k;
  logic running;
  logic lock_lost;
`ifdef PLL_LOCK_CE_GEN_LOSS_COUNT_EN
  logic [7:0] loss_count;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int viol     = 0;
  int pulse_q[$];
  int rise_q[$];
  logic ce_prev  = 1'b0;
  logic crn_prev = 1'b0;

  typedef struct {
    logic locked;
    logic turbo;
    logic pause;
    int   ncyc;
    logic exp_crn;
    logic exp_run;
    logic exp_lost;
    int   exp_pulses;
  } vec_t;

  vec_t tbl[$];

  pll_lock_ce_gen #(
    .CLK_DIV    (CLK_DIV),
    .TURBO_DIV  (TURBO_DIV),
    .LOCK_STABLE(LOCK_STABLE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .turbo       (turbo),
    .pause       (pause),
    .core_reset_n(core_reset_n),
    .ce_32k      (ce_32k),
    .running     (running),
    .lock_lost   (lock_lost)
`ifdef PLL_LOCK_CE_GEN_LOSS_COUNT_EN
    ,
    .loss_count  (loss_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cyc read here names the cycle that began at the preceding posedge.
  always @(negedge clk) begin
    if (ce_32k) pulse_q.push_back(cyc);
    if (core_reset_n && !crn_prev) rise_q.push_back(cyc);
    if (ce_32k && (!core_reset_n || ce_prev)) viol <= viol + 1;
    ce_prev  <= ce_32k;
    crn_prev <= core_reset_n;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(input int c);
    if (cyc < c) tick(c - cyc);
  endtask

  function automatic int pulse_at(input int i);
    return (i < pulse_q.size()) ? pulse_q[i] : -1;
  endfunction

  function automatic int rise_at(input int i);
    return (i < rise_q.size()) ? rise_q[i] : -1;
  endfunction

  task automatic apply_reset(input logic locked);
    reset_n    = 1'b0;
    pll_locked = locked;
    turbo      = 1'b0;
    pause      = 1'b0;
    tick(3);
    reset_n = 1'b1;
  endtask

  task automatic add(input logic l, input logic t, input logic p, input int n,
                     input logic c, input logic r, input logic lo, input int pu);
    vec_t v;
    v = '{l, t, p, n, c, r, lo, pu};
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, rel, rb, pb, base, r, x2, r2;
    int exp_d[6];

    // Bring-up from reset with the stock divider.
    reset_n = 1'b0;
    tick(3);
    @(negedge clk);
    #1;
    check("reset_core_reset_n", core_reset_n, 0);
    check("reset_running", running, 0);
    check("reset_ce_32k", ce_32k, 0);
    check("reset_lock_lost", lock_lost, 0);
`ifdef PLL_LOCK_CE_GEN_LOSS_COUNT_EN
    check("reset_loss_count", loss_count, 0);
`endif
    tick(1);
    reset_n = 1'b1;
    tick(5);
    rb = rise_q.size();
    pb = pulse_q.size();
    c0 = cyc;
    pll_locked = 1'b1;
    rel = c0 + REL;
    goto(rel + 3 * CLK_DIV + 10);
    check("bringup_release_cycle", rise_at(rb), rel);
    // The core consumes ce on the edge after the cycle in which it is high.
    check("bringup_first_ce_latency", pulse_at(pb) + 1 - rel, CLK_DIV);
    check("bringup_period2", pulse_at(pb + 1) - pulse_at(pb), CLK_DIV);
    check("bringup_period3", pulse_at(pb + 2) - pulse_at(pb + 1), CLK_DIV);
    check("bringup_pulse_count", pulse_q.size() - pb, 3);
    check("bringup_running", running, 1);
    check("bringup_lock_lost", lock_lost, 0);

    // Vector table: each record drives inputs for ncyc cycles, then checks flags and pulse count.
    add(0, 0, 0,   20, 0, 0, 0, 0);
    add(1, 0, 0, 1025, 0, 0, 0, 0);
    add(1, 0, 0,    1, 0, 0, 0, 0);
    add(1, 0, 0,    1, 1, 1, 0, 0);  // first RUN cycle, count 0
    add(1, 0, 0,  399, 1, 1, 0, 1);
    add(1, 0, 0,  400, 1, 1, 0, 1);
    add(1, 0, 1,  300, 1, 1, 0, 0);  // paused at count 0
    add(1, 0, 0,  399, 1, 1, 0, 0);
    add(1, 0, 0,    1, 1, 1, 0, 1);
    add(1, 1, 0,  400, 1, 1, 0, 1);  // turbo latched at this wrap
    add(1, 1, 0,  100, 1, 1, 0, 4);
    add(1, 0, 0,   10, 1, 1, 0, 0);
    add(1, 0, 0,   15, 1, 1, 0, 1);  // last turbo period completes
    add(1, 0, 0,  397, 1, 1, 0, 0);
    add(0, 0, 0,    2, 1, 1, 0, 0);  // lk_s still high for counts 397..398
    add(0, 0, 0,    1, 1, 1, 0, 0);  // count 399 with lock lost: no pulse
    add(0, 0, 0,    1, 0, 0, 1, 0);
    add(0, 0, 0,   50, 0, 0, 1, 0);
    add(1, 0, 0, 1025, 0, 0, 1, 0);
    add(1, 0, 0,    1, 0, 0, 1, 0);
    add(1, 0, 0,    1, 1, 1, 1, 0);
    add(1, 0, 0,  398, 1, 1, 1, 0);
    add(1, 0, 0,    1, 1, 1, 1, 1);
    add(1, 0, 0,  399, 1, 1, 1, 0);
    add(1, 0, 1,    1, 1, 1, 1, 0);  // pause on the wrap cycle
    add(1, 0, 1,   10, 1, 1, 1, 0);
    add(1, 0, 0,    1, 1, 1, 1, 1);
    add(1, 0, 0,  399, 1, 1, 1, 0);
    add(1, 0, 0,    1, 1, 1, 1, 1);

    apply_reset(1'b0);
    foreach (tbl[i]) begin
      pll_locked = tbl[i].locked;
      turbo      = tbl[i].turbo;
      pause      = tbl[i].pause;
      base       = pulse_q.size();
      tick(tbl[i].ncyc - 1);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_flags", i), {core_reset_n, running, lock_lost},
            {tbl[i].exp_crn, tbl[i].exp_run, tbl[i].exp_lost});
      check($sformatf("vec%0d_pulses", i), pulse_q.size() - base, tbl[i].exp_pulses);
      @(posedge clk);
      #1;
    end
`ifdef PLL_LOCK_CE_GEN_LOSS_COUNT_EN
    check("loss_count_after_one_loss", loss_count, 1);
`endif

    // Lock glitch of 3 clk while the stable counter reads 700.
    apply_reset(1'b0);
    tick(3);
    rb = rise_q.size();
    c0 = cyc;
    pll_locked = 1'b1;
    goto(c0 + 700);
    pll_locked = 1'b0;
    goto(c0 + 703);
    pll_locked = 1'b1;
    goto(c0 + 700 + 1029 + 5);
    check("glitch_release_cycle", rise_at(rb), c0 + 700 + 5 + LOCK_STABLE);
    check("glitch_release_count", rise_q.size() - rb, 1);

    // Turbo toggled mid-period, then a pause spanning the wrap.
    apply_reset(1'b1);
    rb = rise_q.size();
    pb = pulse_q.size();
    r  = cyc + REL;
    goto(r + 100);
    turbo = 1'b1;
    goto(r + 430);
    turbo = 1'b0;
    goto(r + 1230);
    pause = 1'b1;
    goto(r + 1280);
    pause = 1'b0;
    goto(r + 1705);
    check("turbo_release_cycle", rise_at(rb), r);
    exp_d = '{r + 399, r + 424, r + 449, r + 849, r + 1299, r + 1699};
    for (int k = 0; k < 6; k++) begin
      check($sformatf("turbo_pause_pulse%0d", k), pulse_at(pb + k), exp_d[k]);
    end
    check("turbo_pause_pulse_count", pulse_q.size() - pb, 6);

    // Asynchronous reset at divider count 250, then re-lock with pll_locked held.
    goto(r + 1950);
    check("pre_reset_core_reset_n", core_reset_n, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_core_reset_n", core_reset_n, 0);
    check("async_running", running, 0);
    check("async_ce_32k", ce_32k, 0);
    check("async_lock_lost", lock_lost, 0);
    tick(3);
    reset_n = 1'b1;
    x2 = cyc;
    r2 = x2 + REL;
    rb = rise_q.size();
    pb = pulse_q.size();
    goto(r2 + CLK_DIV + 5);
    check("rerun_release_cycle", rise_at(rb), r2);
    check("rerun_first_pulse", pulse_at(pb), r2 + CLK_DIV - 1);
    check("rerun_pulse_count", pulse_q.size() - pb, 1);

    tick(2);
    check("ce_invariant_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
